// File: rtl/calc_tag_tracker_if.sv
// Snooped request/response lanes of the calculator DUT bus.
// master drives the lanes, slave observes them.
interface calc_tag_tracker_if #(
    parameter int NUM_PORTS = 4,
    parameter int CMD_W     = 4,
    parameter int TAG_W     = 2
) ();
    logic [NUM_PORTS*CMD_W-1:0] req_cmd_in;
    logic [NUM_PORTS*TAG_W-1:0] req_tag_in;
    logic [NUM_PORTS*2-1:0]     out_resp;
    logic [NUM_PORTS*TAG_W-1:0] out_tag;

    modport master (
        output req_cmd_in,
        output req_tag_in,
        output out_resp,
        output out_tag
    );

    modport slave (
        input req_cmd_in,
        input req_tag_in,
        input out_resp,
        input out_tag
    );
endinterface

// File: rtl/calc_tag_tracker.sv
// calc_tag_tracker: per-port outstanding-tag tracker with error pulses.
// Completion counters built only with CALC_TAG_TRACKER_STATS_EN.
module calc_tag_tracker #(
    parameter int NUM_PORTS = 4,
    parameter int CMD_W     = 4,
    parameter int TAG_W     = 2,
    parameter int TIMEOUT   = 64,
    parameter int AGE_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                           c_clk,
    input  logic                           reset_n,
    calc_tag_tracker_if.slave              bus,
    input  logic                           clr_err,
    output logic [NUM_PORTS*(TAG_W+1)-1:0] outstanding,
    output logic [NUM_PORTS-1:0]           err_dup_tag,
    output logic [NUM_PORTS-1:0]           err_unexp_resp,
    output logic [NUM_PORTS-1:0]           err_timeout,
    output logic [2:0]                     err_sticky,
    output logic [NUM_PORTS*16-1:0]        cpl_cnt
);
    localparam int ENTRIES = 2 ** TAG_W;
    localparam int CNT_W   = TAG_W + 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

    logic [NUM_PORTS-1:0] dup_d;
    logic [NUM_PORTS-1:0] unexp_d;
    logic [NUM_PORTS-1:0] to_pend;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic               req_v;
        logic               rsp_v;
        logic [TAG_W-1:0]   req_tag;
        logic [TAG_W-1:0]   rsp_tag;
        logic [ENTRIES-1:0] valid_q;
        logic [ENTRIES-1:0] valid_d;
        logic [AGE_W-1:0]   age_q [ENTRIES];
        logic [AGE_W-1:0]   age_d [ENTRIES];
        logic               to_hit;
        logic               to_pend_q;
        logic               dup_n;
        logic               unexp_n;
        logic [CNT_W-1:0]   cnt_d;
        logic [CNT_W-1:0]   cnt_q;
        logic               dup_q;
        logic               unexp_q;
        logic               to_q;

        assign req_v   = |bus.req_cmd_in[p*CMD_W +: CMD_W];
        assign rsp_v   = |bus.out_resp[p*2 +: 2];
        assign req_tag = bus.req_tag_in[p*TAG_W +: TAG_W];
        assign rsp_tag = bus.out_tag[p*TAG_W +: TAG_W];

        // Age entries, then retire on response, then arm on request
        always_comb begin
            valid_d = valid_q;
            to_hit  = 1'b0;
            dup_n   = 1'b0;
            unexp_n = 1'b0;
            for (int t = 0; t < ENTRIES; t++) begin
                age_d[t] = age_q[t];
                if (valid_q[t]) begin
                    if (age_q[t] == AGE_LAST &&
                        !(rsp_v && rsp_tag == TAG_W'(t))) begin
                        valid_d[t] = 1'b0;
                        age_d[t]   = '0;
                        to_hit     = 1'b1;
                    end else begin
                        age_d[t] = age_q[t] + AGE_W'(1);
                    end
                end
            end
            if (rsp_v) begin
                if (valid_d[rsp_tag]) begin
                    valid_d[rsp_tag] = 1'b0;
                end else begin
                    unexp_n = 1'b1;
                end
            end
            if (req_v) begin
                dup_n            = valid_d[req_tag];
                valid_d[req_tag] = 1'b1;
                age_d[req_tag]   = '0;
            end
            cnt_d = '0;
            for (int t = 0; t < ENTRIES; t++) begin
                cnt_d = cnt_d + CNT_W'(valid_d[t]);
            end
        end

        // Entry state and registered per-port outputs
        always_ff @(posedge c_clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q   <= '0;
                for (int t = 0; t < ENTRIES; t++) begin
                    age_q[t] <= '0;
                end
                to_pend_q <= 1'b0;
                cnt_q     <= '0;
                dup_q     <= 1'b0;
                unexp_q   <= 1'b0;
                to_q      <= 1'b0;
            end else begin
                valid_q   <= valid_d;
                for (int t = 0; t < ENTRIES; t++) begin
                    age_q[t] <= age_d[t];
                end
                to_pend_q <= to_hit;
                cnt_q     <= cnt_d;
                dup_q     <= dup_n;
                unexp_q   <= unexp_n;
                to_q      <= to_pend_q;
            end
        end

        assign dup_d[p]   = dup_n;
        assign unexp_d[p] = unexp_n;
        assign to_pend[p] = to_pend_q;

        assign outstanding[p*CNT_W +: CNT_W] = cnt_q;
        assign err_dup_tag[p]    = dup_q;
        assign err_unexp_resp[p] = unexp_q;
        assign err_timeout[p]    = to_q;

`ifdef CALC_TAG_TRACKER_STATS_EN
        logic [15:0] cpl_q;
        logic        cpl_hit;

        // A response retires an entry only if it was valid before aging
        assign cpl_hit = rsp_v & valid_q[rsp_tag];

        // Saturating completion counter
        always_ff @(posedge c_clk or negedge reset_n) begin
            if (!reset_n) begin
                cpl_q <= '0;
            end else if (cpl_hit && cpl_q != 16'hFFFF) begin
                cpl_q <= cpl_q + 16'd1;
            end
        end

        assign cpl_cnt[p*16 +: 16] = cpl_q;
`endif
    end

`ifndef CALC_TAG_TRACKER_STATS_EN
    assign cpl_cnt = '0;
`endif

    // Sticky flags track the pulses; a new pulse beats clr_err
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= '0;
        end else begin
            err_sticky[0] <= (|dup_d) | (err_sticky[0] & ~clr_err);
            err_sticky[1] <= (|unexp_d) | (err_sticky[1] & ~clr_err);
            err_sticky[2] <= (|to_pend) | (err_sticky[2] & ~clr_err);
        end
    end
endmodule
